// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues word fetches to InstructionMemory
// and buffers the returned words in a small tagged FIFO presented to decode via valid/ready.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRED_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [31:0]           instr_buf_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_buf_q    [FIFO_DEPTH];

    logic [CRED_W-1:0] credit_used;
    logic              issue;
    logic              push;
    logic              pop;

    // In-flight fetches reserve a slot, so a returning word always finds room.
    assign credit_used = CRED_W'(count_q) + CRED_W'(resp_valid_q);
    assign issue       = fetch_en & ~redirect_valid & (credit_used < CRED_W'(FIFO_DEPTH));
    assign push        = resp_valid_q & ~redirect_valid;
    assign pop         = out_valid & out_ready;

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_buf_q[rd_ptr_q];
    assign out_pc    = pc_buf_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_valid_d = issue;
        resp_pc_d    = resp_pc_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;

        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc & ~ADDR_WIDTH'(3);
            resp_valid_d = 1'b0;
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                resp_pc_d  = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // Storage is cleared on reset so the head outputs read as zero until the first capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_buf_q[i] <= '0;
                pc_buf_q[i]    <= '0;
            end
        end else if (push) begin
            instr_buf_q[wr_ptr_q] <= imem_instr;
            pc_buf_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand-written corner
// sequences and a randomized run compared against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_instr;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc;
    logic          out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready)
    );

    // Instruction memory content is a fixed scramble of the address, so any PC has a known word.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    always @(posedge clk) imem_instr <= memWord(imem_addr);

    // Reference model: the buffer is a queue of {pc, instr}; at most one word is in flight.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mQ[$];
    logic [31:0] mFetchPc    = 32'h0;
    logic        mInflight   = 1'b0;
    logic [31:0] mInflightPc = 32'h0;

    task automatic modelStep();
        int     occupied;
        bit     doIssue;
        entry_t e;
        if (!rst_n) begin
            mQ.delete();
            mFetchPc  = 32'h0;
            mInflight = 1'b0;
        end else if (redirect_valid) begin
            mQ.delete();
            mInflight = 1'b0;
            mFetchPc  = {redirect_pc[31:2], 2'b00};
        end else begin
            occupied = mQ.size() + int'(mInflight);
            doIssue  = fetch_en && (occupied < DEPTH);
            if (mQ.size() != 0 && out_ready) void'(mQ.pop_front());
            if (mInflight) begin
                e.pc    = mInflightPc;
                e.instr = memWord(mInflightPc);
                mQ.push_back(e);
            end
            mInflight = doIssue;
            if (doIssue) begin
                mInflightPc = mFetchPc;
                mFetchPc    = mFetchPc + 32'd4;
            end
        end
    endtask

    task automatic checkEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic fe, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst_n          = rn;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic inReset, input logic expValid,
                               input logic [31:0] expPc, input logic [31:0] expAddr);
        checkEq({tag, "_valid"}, {31'b0, out_valid}, {31'b0, expValid});
        checkEq({tag, "_addr"}, imem_addr, expAddr);
        if (expValid) begin
            checkEq({tag, "_pc"}, out_pc, expPc);
            checkEq({tag, "_instr"}, out_instr, memWord(expPc));
        end
        if (inReset) begin
            checkEq({tag, "_rstpc"}, out_pc, 32'h0);
            checkEq({tag, "_rstinstr"}, out_instr, 32'h0);
        end
    endtask

    task automatic checkModel(input int cyc);
        string tag;
        tag = $sformatf("rand%0d", cyc);
        checkEq({tag, "_valid"}, {31'b0, out_valid}, {31'b0, (mQ.size() != 0)});
        checkEq({tag, "_addr"}, imem_addr, mFetchPc);
        if (mQ.size() != 0) begin
            checkEq({tag, "_pc"}, out_pc, mQ[0].pc);
            checkEq({tag, "_instr"}, out_instr, mQ[0].instr);
        end
    endtask

    task automatic step(input string tag, input logic rn, input logic fe, input logic rv,
                        input logic [31:0] rpc, input logic rdy,
                        input logic ev, input logic [31:0] epc, input logic [31:0] ea);
        applyStimulus(rn, fe, rv, rpc, rdy);
        checkOutput(tag, !rn, ev, epc, ea);
    endtask

    typedef struct {
        logic        rstN;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        // Reset then stream with fetch_en=1 and out_ready=1.
        v = '{1'b0, 1'b0, 32'h0, 32'h0};  vecs.push_back(v); vecs.push_back(v);
        v = '{1'b1, 1'b0, 32'h0, 32'h4};  vecs.push_back(v);
        for (int i = 0; i < 14; i++) begin
            v = '{1'b1, 1'b1, 32'(4 * i), 32'(4 * i + 8)};
            vecs.push_back(v);
        end
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstN, 1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("stream%0d", i), !vecs[i].rstN, vecs[i].expValid,
                        vecs[i].expPc, vecs[i].expAddr);
        end

        // Backpressure: FIFO fills to four entries, address freezes, then drains without gaps.
        step("bp_rst", 0, 1, 0, 32'h0, 0, 0, 32'h0,  32'h0);
        step("bp_e1",  1, 1, 0, 32'h0, 0, 0, 32'h0,  32'h4);
        step("bp_e2",  1, 1, 0, 32'h0, 0, 1, 32'h0,  32'h8);
        step("bp_e3",  1, 1, 0, 32'h0, 0, 1, 32'h0,  32'hC);
        step("bp_e4",  1, 1, 0, 32'h0, 0, 1, 32'h0,  32'h10);
        step("bp_e5",  1, 1, 0, 32'h0, 0, 1, 32'h0,  32'h10);
        step("bp_e6",  1, 1, 0, 32'h0, 0, 1, 32'h0,  32'h10);
        step("bp_e7",  1, 1, 0, 32'h0, 1, 1, 32'h4,  32'h10);
        step("bp_e8",  1, 1, 0, 32'h0, 1, 1, 32'h8,  32'h14);
        step("bp_e9",  1, 1, 0, 32'h0, 1, 1, 32'hC,  32'h18);
        step("bp_e10", 1, 1, 0, 32'h0, 1, 1, 32'h10, 32'h1C);
        step("bp_e11", 1, 1, 0, 32'h0, 1, 1, 32'h14, 32'h20);

        // Redirect while pc 8/12 are buffered and pc 16 is in flight.
        step("rd_rst", 0, 1, 0, 32'h0,  0, 0, 32'h0,  32'h0);
        step("rd_e1",  1, 1, 0, 32'h0,  0, 0, 32'h0,  32'h4);
        step("rd_e2",  1, 1, 0, 32'h0,  0, 1, 32'h0,  32'h8);
        step("rd_e3",  1, 1, 0, 32'h0,  1, 1, 32'h4,  32'hC);
        step("rd_e4",  1, 1, 0, 32'h0,  1, 1, 32'h8,  32'h10);
        step("rd_e5",  1, 1, 0, 32'h0,  0, 1, 32'h8,  32'h14);
        step("rd_e6",  1, 1, 1, 32'h28, 0, 0, 32'h0,  32'h28);
        step("rd_e7",  1, 1, 0, 32'h0,  1, 0, 32'h0,  32'h2C);
        step("rd_e8",  1, 1, 0, 32'h0,  1, 1, 32'h28, 32'h30);
        step("rd_e9",  1, 1, 0, 32'h0,  1, 1, 32'h2C, 32'h34);

        // Misaligned redirect together with a pop handshake.
        step("mis_e1", 1, 1, 1, 32'h33, 1, 0, 32'h0,  32'h30);
        step("mis_e2", 1, 1, 0, 32'h0,  1, 0, 32'h0,  32'h34);
        step("mis_e3", 1, 1, 0, 32'h0,  1, 1, 32'h30, 32'h38);

        // fetch_en gating: the single in-flight word is still delivered.
        step("fe_e1",  1, 0, 0, 32'h0, 1, 1, 32'h34, 32'h38);
        step("fe_e2",  1, 0, 0, 32'h0, 1, 0, 32'h0,  32'h38);
        step("fe_e3",  1, 0, 0, 32'h0, 1, 0, 32'h0,  32'h38);
        step("fe_e4",  1, 1, 0, 32'h0, 1, 0, 32'h0,  32'h3C);
        step("fe_e5",  1, 1, 0, 32'h0, 1, 1, 32'h38, 32'h40);
        step("fe_e6",  1, 1, 0, 32'h0, 1, 1, 32'h3C, 32'h44);

        // Fill the FIFO, then reset with a simultaneous redirect.
        step("rs_e1",  1, 1, 0, 32'h0,  0, 1, 32'h3C, 32'h48);
        step("rs_e2",  1, 1, 0, 32'h0,  0, 1, 32'h3C, 32'h4C);
        step("rs_e3",  1, 1, 0, 32'h0,  0, 1, 32'h3C, 32'h4C);
        step("rs_e4",  1, 1, 0, 32'h0,  0, 1, 32'h3C, 32'h4C);
        step("rs_e5",  0, 1, 1, 32'h80, 0, 0, 32'h0,  32'h0);
        step("rs_e6",  1, 1, 0, 32'h0,  1, 0, 32'h0,  32'h4);
        step("rs_e7",  1, 1, 0, 32'h0,  1, 1, 32'h0,  32'h8);

        // Randomized run against the reference model.
        applyStimulus(0, 0, 0, 32'h0, 0);
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 63) != 0,
                          $urandom_range(0, 9) < 8,
                          $urandom_range(0, 15) == 0,
                          $urandom,
                          $urandom_range(0, 9) < 7);
            checkModel(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Initiator side of the instruction-memory interface. The block owns the fetch PC and drives word addresses into InstructionMemory. It captures the returned instructions into a small tagged prefetch FIFO and presents {pc, instruction} pairs to decode over a valid/ready handshake. Branch/jump redirects flush all buffered and in-flight fetches.

Parameters:
ADDR_WIDTH, 32, byte-address width of PC and memory address
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
FIFO_DEPTH, 4, prefetch entries (power of two, >=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
fetch_en  in  1  permits issuing new fetches
imem_addr  out  ADDR_WIDTH  byte address to InstructionMemory (from fetch_pc register)
imem_instr  in  32  instruction word, valid the cycle after the address was issued
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  new fetch target
out_valid  out  1  FIFO head holds a valid instruction
out_instr  out  32  head instruction
out_pc  out  ADDR_WIDTH  byte address of head instruction
out_ready  in  1  decode accepts the head this cycle

Behaviour:
- Interface: clock is clk; reset rst_n is synchronous, active-low; no other clocks or resets.
- Reset (rst_n=0 at posedge): fetch_pc=RESET_PC; FIFO count=0, rd/wr pointers=0; resp_valid_q=0; out_valid=0; out_instr=0; out_pc=0. Reset overrides everything, including a redirect in the same cycle; an in-flight response is discarded.
- Memory timing: imem_addr=fetch_pc continuously. A fetch is "issued" in cycle t when issue=1, and the word returns on imem_instr in cycle t+1.
- Issue condition: issue = fetch_en & ~redirect_valid & (count + resp_valid_q < FIFO_DEPTH). A pop in the same cycle is not credited.
- On issue: fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH); resp_valid_q<=1; resp_pc_q<=fetch_pc. Otherwise resp_valid_q<=0 and fetch_pc holds.
- Capture: in any cycle with resp_valid_q=1 and no redirect, {resp_pc_q, imem_instr} is written at wr_ptr.
- Pop: when out_valid & out_ready, rd_ptr advances.
- Push and pop in the same cycle: count is unchanged; both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Issue credit guarantees a push never hits a full FIFO. A push while count==FIFO_DEPTH is a design error; an assertion flags it.
- Output: out_valid = (count!=0). out_instr/out_pc show the head entry combinationally from FIFO storage and hold stable while out_valid & ~out_ready.
- Throughput: with fetch_en=1 and out_ready=1 continuously, one instruction per cycle sustained.
- Latency: first out_valid appears 2 cycles after rst_n deasserts or after a redirect (issue cycle, then capture cycle).
- Redirect (highest priority after reset), in the cycle it is asserted:
  - FIFO cleared (count=0, pointers=0).
  - resp_valid_q<=0, so the in-flight word is dropped.
  - No capture and no issue.
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; misaligned low bits are silently cleared.
  - out_valid is 0 from the next cycle. A pop handshake in the redirect cycle still completes for decode, but the FIFO is cleared regardless.
- fetch_en=0: no new issues. An already-issued response is still captured, and buffered entries still drain.
- No state machine beyond issue/capture pipeline plus FIFO. States are implied by count (EMPTY, PARTIAL, FULL) and resp_valid_q (IDLE, WAIT).

Test Plan:
- Reset then stream: rst_n low 2 cycles, fetch_en=1, out_ready=1, memory preloaded -> out_pc = 0, 4, 8, ..., 52 on consecutive cycles starting 2 cycles after reset release; out_instr matches memory words 0..13.
- Backpressure: out_ready=0 from cycle 3 -> FIFO fills to 4 entries (pc 0..12); imem_addr freezes at 16; out_pc=0 held stable. Release out_ready -> pc 0, 4, 8, 12, 16 delivered with no gap or duplicate.
- Redirect mid-stream: redirect_valid=1, redirect_pc=0x28 while FIFO holds pc 8, 12 and pc 16 is in flight -> pc 8/12/16 never appear; next out_valid 2 cycles later with out_pc=0x28, then 0x2C.
- Misaligned redirect plus simultaneous pop: redirect_pc=0x33 with out_valid & out_ready -> subsequent out_pc=0x30; count=0 in the following cycle.
- fetch_en gating: drop fetch_en for 3 cycles -> exactly one in-flight word is captured; imem_addr holds; after re-enable, pcs continue contiguously.
- Reset mid-operation: rst_n=0 with full FIFO and redirect_valid=1 -> next cycle out_valid=0, imem_addr=RESET_PC; the redirect is ignored.
